// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 16:1 mux datapath.
// A grant is held until done, request withdrawal, or timeout; priority then rotates past the owner.
module mux16_rr_arbiter #(
    parameter int N       = 16,
    parameter int SELW    = 4,
    parameter int TIMEOUT = 200
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [SELW-1:0] sel,
    output logic [N-1:0]    grant,
    output logic            busy,
    output logic            timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        REL
    } state_t;

    localparam logic [7:0]   CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [N-1:0] ONE_HOT0 = N'(1);

    state_t          state;
    logic [SELW-1:0] ptr;
    logic [7:0]      cnt;
    logic [SELW-1:0] winner;
    logic [SELW-1:0] idx;
    logic            any_req;
    logic            release_now;

    // Scan ptr, ptr+1, ... with natural 4-bit wrap; first requester found wins.
    always_comb begin
        winner  = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + SELW'(i);
            if (!any_req && req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

    assign release_now = done || !req[sel] || (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            ptr         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel   <= winner;
                        grant <= ONE_HOT0 << winner;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                    if (release_now) begin
                        grant       <= '0;
                        busy        <= 1'b0;
                        ptr         <= sel + SELW'(1);
                        // Only a pure timeout flags an error; done or abandon take precedence.
                        timeout_err <= !done && req[sel];
                        state       <= REL;
                    end
                end
                REL: begin
                    timeout_err <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed testbench for mux16_rr_arbiter, built with TIMEOUT=5 so timeouts are short.
module tb_mux16_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        busy;
    logic        timeout_err;

    int checks;
    int errors;

    mux16_rr_arbiter #(.N(16), .SELW(4), .TIMEOUT(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .sel         (sel),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running required done");
        $fatal(1, "watchdog expired");
    end

    // One rising edge, then return at the falling edge where inputs change and outputs are sampled.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 16'hFFFF;
        done  = 1'b0;
        repeat (3) tick();
        checks++;
        if (sel !== 4'd0) begin
            errors++;
            $display("FAIL reset_sel: got %0d required 0", sel);
        end
        checks++;
        if (grant !== 16'h0000) begin
            errors++;
            $display("FAIL reset_grant: got %h required 0000", grant);
        end
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b terr=%b required 0 0", busy, timeout_err);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (grant !== 16'h0001 || sel !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: got grant=%h sel=%0d busy=%b required 0001 0 1",
                     grant, sel, busy);
        end
        // done outside BUSY must not matter: re-enter IDLE and pulse done with no requests
        do_reset();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (grant !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_done: got grant=%h busy=%b required 0000 0", grant, busy);
        end
    endtask

    task automatic test_rotation();
        logic [15:0] exp_grant [3];
        logic [3:0]  exp_sel [3];
        exp_grant[0] = 16'h0001; exp_sel[0] = 4'd0;
        exp_grant[1] = 16'h0010; exp_sel[1] = 4'd4;
        exp_grant[2] = 16'h0001; exp_sel[2] = 4'd0;
        do_reset();
        req = 16'h0011;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (grant !== exp_grant[i] || sel !== exp_sel[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL rotation_grant%0d: got grant=%h sel=%0d busy=%b required %h %0d 1",
                         i, grant, sel, busy, exp_grant[i], exp_sel[i]);
            end
            tick();
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (grant !== 16'h0000 || busy !== 1'b0 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL rotation_release%0d: got grant=%h busy=%b terr=%b required 0000 0 0",
                         i, grant, busy, timeout_err);
            end
            tick();
            checks++;
            if (grant !== 16'h0000) begin
                errors++;
                $display("FAIL rotation_gap%0d: got grant=%h required 0000", i, grant);
            end
            tick();
        end
        req = '0;
    endtask

    task automatic test_wrap();
        do_reset();
        req = 16'h8000;
        tick();
        req = 16'h8004;
        checks++;
        if (grant !== 16'h8000 || sel !== 4'd15) begin
            errors++;
            $display("FAIL wrap_owner15: got grant=%h sel=%0d required 8000 15", grant, sel);
        end
        tick();
        checks++;
        if (grant !== 16'h8000) begin
            errors++;
            $display("FAIL wrap_hold: got grant=%h required 8000", grant);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (grant !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_release: got grant=%h busy=%b required 0000 0", grant, busy);
        end
        tick();
        tick();
        checks++;
        if (grant !== 16'h0004 || sel !== 4'd2) begin
            errors++;
            $display("FAIL wrap_next: got grant=%h sel=%0d required 0004 2", grant, sel);
        end
        req = '0;
    endtask

    task automatic test_timeout();
        do_reset();
        req = 16'h0100;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (grant !== 16'h0100 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold%0d: got grant=%h terr=%b required 0100 0",
                         i, grant, timeout_err);
            end
            tick();
        end
        checks++;
        if (grant !== 16'h0000 || timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_release: got grant=%h terr=%b busy=%b required 0000 1 0",
                     grant, timeout_err, busy);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0 || grant !== 16'h0000) begin
            errors++;
            $display("FAIL timeout_pulse: got terr=%b grant=%h required 0 0000", timeout_err, grant);
        end
        tick();
        checks++;
        if (grant !== 16'h0100 || sel !== 4'd8 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_regrant: got grant=%h sel=%0d terr=%b required 0100 8 0",
                     grant, sel, timeout_err);
        end
        req = '0;
    endtask

    task automatic test_done_timeout();
        do_reset();
        req = 16'h0100;
        tick();
        repeat (4) tick();
        checks++;
        if (grant !== 16'h0100) begin
            errors++;
            $display("FAIL done_to_hold: got grant=%h required 0100", grant);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (grant !== 16'h0000 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL done_to_release: got grant=%h terr=%b required 0000 0", grant, timeout_err);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL done_to_noerr: got terr=%b required 0", timeout_err);
        end
        req = '0;
    endtask

    task automatic test_abandon_reset();
        do_reset();
        req = 16'h0008;
        tick();
        checks++;
        if (grant !== 16'h0008 || sel !== 4'd3) begin
            errors++;
            $display("FAIL abandon_owner3: got grant=%h sel=%0d required 0008 3", grant, sel);
        end
        tick();
        req = 16'h0000;
        tick();
        checks++;
        if (grant !== 16'h0000 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL abandon_release: got grant=%h busy=%b terr=%b required 0000 0 0",
                     grant, busy, timeout_err);
        end
        req = 16'h0048;
        tick();
        tick();
        checks++;
        if (grant !== 16'h0040 || sel !== 4'd6) begin
            errors++;
            $display("FAIL abandon_ptr4: got grant=%h sel=%0d required 0040 6", grant, sel);
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got grant=%h busy=%b required 0000 0", grant, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (grant !== 16'h0008 || sel !== 4'd3) begin
            errors++;
            $display("FAIL reset_restart: got grant=%h sel=%0d required 0008 3", grant, sel);
        end
        req = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = '0;
        done   = 1'b0;
        @(negedge clk);
        test_reset();
        test_rotation();
        test_wrap();
        test_timeout();
        test_done_timeout();
        test_abandon_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
